// File: rtl/alu_issue_unit.sv
// rtl/alu_issue_unit.sv - multi-cycle RISC-V ALU request front end driving a 3-bit-mode ALU
module alu_issue_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_funct3,
    input  logic                  req_alt,
    input  logic                  req_use_imm,
    input  logic                  req_lui,
    input  logic [DATA_WIDTH-1:0] req_rs1,
    input  logic [DATA_WIDTH-1:0] req_rs2,
    input  logic [DATA_WIDTH-1:0] req_imm,
    output logic [2:0]            alu_mode,
    output logic [DATA_WIDTH-1:0] alu_op1,
    output logic [DATA_WIDTH-1:0] alu_op2,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic                  resp_err,
    output logic                  busy
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [2:0] M_ADD  = 3'd0;
    localparam logic [2:0] M_SUB  = 3'd1;
    localparam logic [2:0] M_AND  = 3'd2;
    localparam logic [2:0] M_OR   = 3'd3;
    localparam logic [2:0] M_XOR  = 3'd4;
    localparam logic [2:0] M_SLL  = 3'd5;
    localparam logic [2:0] M_SRL  = 3'd6;
    localparam logic [2:0] M_PASS = 3'd7;

    localparam logic [DATA_WIDTH-1:0] SHAMT_MASK =
        DATA_WIDTH'((64'd1 << SHAMT_WIDTH) - 64'd1);

    logic [1:0]            state_q, state_d;
    logic [2:0]            alu_mode_q, alu_mode_d;
    logic [DATA_WIDTH-1:0] alu_op1_q, alu_op1_d;
    logic [DATA_WIDTH-1:0] alu_op2_q, alu_op2_d;
    logic                  err_q, err_d;
    logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;
    logic                  resp_err_q, resp_err_d;

    logic [2:0]            dec_mode;
    logic                  dec_err;
    logic                  dec_shift;
    logic [DATA_WIDTH-1:0] op2_sel;

    // Decode straight from the request so the ALU drive is registered and stable for all of EXEC.
    always_comb begin
        dec_mode  = M_ADD;
        dec_err   = 1'b0;
        dec_shift = 1'b0;
        if (req_lui) begin
            dec_mode = M_PASS;
        end else begin
            case (req_funct3)
                3'b000: dec_mode = (req_alt && !req_use_imm) ? M_SUB : M_ADD;
                3'b111: dec_mode = M_AND;
                3'b110: dec_mode = M_OR;
                3'b100: dec_mode = M_XOR;
                3'b001: begin
                    dec_mode  = M_SLL;
                    dec_shift = 1'b1;
                end
                3'b101: begin
                    if (req_alt) begin
                        dec_err = 1'b1;
                    end else begin
                        dec_mode  = M_SRL;
                        dec_shift = 1'b1;
                    end
                end
                default: dec_err = 1'b1;
            endcase
        end
    end

    assign op2_sel = req_use_imm ? req_imm : req_rs2;

    always_comb begin
        state_d     = state_q;
        alu_mode_d  = alu_mode_q;
        alu_op1_d   = alu_op1_q;
        alu_op2_d   = alu_op2_q;
        err_d       = err_q;
        resp_data_d = resp_data_q;
        resp_err_d  = resp_err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d    = ST_EXEC;
                    alu_mode_d = dec_mode;
                    alu_op1_d  = req_lui ? req_imm : req_rs1;
                    alu_op2_d  = dec_shift ? (op2_sel & SHAMT_MASK) : op2_sel;
                    err_d      = dec_err;
                end
            end
            ST_EXEC: begin
                resp_data_d = err_q ? '0 : alu_out;
                resp_err_d  = err_q;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            alu_mode_q  <= '0;
            alu_op1_q   <= '0;
            alu_op2_q   <= '0;
            err_q       <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            alu_mode_q  <= alu_mode_d;
            alu_op1_q   <= alu_op1_d;
            alu_op2_q   <= alu_op2_d;
            err_q       <= err_d;
            resp_data_q <= resp_data_d;
            resp_err_q  <= resp_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign resp_valid = (state_q == ST_RESP);
    assign busy       = (state_q != ST_IDLE);
    assign alu_mode   = alu_mode_q;
    assign alu_op1    = alu_op1_q;
    assign alu_op2    = alu_op2_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_issue_unit.sv
// tb/tb_alu_issue_unit.sv - directed self-checking bench for alu_issue_unit
module tb_alu_issue_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_funct3;
    logic        req_alt;
    logic        req_use_imm;
    logic        req_lui;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic [31:0] req_imm;
    logic [2:0]  alu_mode;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [31:0] alu_out;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_issue_unit #(.DATA_WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_funct3 (req_funct3),
        .req_alt    (req_alt),
        .req_use_imm(req_use_imm),
        .req_lui    (req_lui),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .req_imm    (req_imm),
        .alu_mode   (alu_mode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_out    (alu_out),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .busy       (busy)
    );

    // The external ALU the unit drives.
    always_comb begin
        case (alu_mode)
            3'd0: alu_out = alu_op1 + alu_op2;
            3'd1: alu_out = alu_op1 - alu_op2;
            3'd2: alu_out = alu_op1 & alu_op2;
            3'd3: alu_out = alu_op1 | alu_op2;
            3'd4: alu_out = alu_op1 ^ alu_op2;
            3'd5: alu_out = alu_op1 << alu_op2;
            3'd6: alu_out = alu_op1 >> alu_op2;
            default: alu_out = alu_op1;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input logic [2:0] f3, input logic alt, input logic ui, input logic lui,
                           input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] imm);
        req_valid   = 1'b1;
        req_funct3  = f3;
        req_alt     = alt;
        req_use_imm = ui;
        req_lui     = lui;
        req_rs1     = rs1;
        req_rs2     = rs2;
        req_imm     = imm;
    endtask

    // One full transaction; chk_ops=0 skips operand checks where they are unspecified.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic alt, input logic ui,
                          input logic lui, input logic [31:0] rs1, input logic [31:0] rs2,
                          input logic [31:0] imm, input logic chk_ops, input logic [2:0] exp_mode,
                          input logic [31:0] exp_op1, input logic [31:0] exp_op2,
                          input logic [31:0] exp_data, input logic exp_err);
        @(negedge clk);
        set_req(f3, alt, ui, lui, rs1, rs2, imm);
        @(negedge clk);
        req_valid = 1'b0;
        chk({tag, "_exec_busy"}, busy, 1);
        chk({tag, "_exec_ready"}, req_ready, 0);
        chk({tag, "_exec_rvalid"}, resp_valid, 0);
        chk({tag, "_mode"}, alu_mode, exp_mode);
        if (chk_ops) begin
            chk({tag, "_op1"}, alu_op1, exp_op1);
            chk({tag, "_op2"}, alu_op2, exp_op2);
        end
        @(negedge clk);
        chk({tag, "_rvalid"}, resp_valid, 1);
        chk({tag, "_data"}, resp_data, exp_data);
        chk({tag, "_err"}, resp_err, exp_err);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk({tag, "_done_rvalid"}, resp_valid, 0);
        chk({tag, "_done_ready"}, req_ready, 1);
    endtask

    initial begin
        rst_n      = 1'b0;
        resp_ready = 1'b0;
        set_req(3'b000, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0);
        req_valid  = 1'b0;
        #3;
        chk("rst_ready", req_ready, 1);
        chk("rst_rvalid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_mode", alu_mode, 0);
        chk("rst_op1", alu_op1, 0);
        chk("rst_op2", alu_op2, 0);
        chk("rst_data", resp_data, 0);
        chk("rst_err", resp_err, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("sub",  3'b000, 1, 0, 0, 32'h0, 32'h1, 32'h0, 1, 3'd1, 32'h0, 32'h1, 32'hFFFF_FFFF, 0);
        run_op("addi", 3'b000, 1, 1, 0, 32'h0, 32'h1, 32'h1, 1, 3'd0, 32'h0, 32'h1, 32'h1, 0);
        run_op("sll",  3'b001, 0, 0, 0, 32'h1, 32'h25, 32'h0, 1, 3'd5, 32'h1, 32'h5, 32'h20, 0);
        run_op("srl",  3'b101, 0, 1, 0, 32'h8000_0000, 32'h0, 32'h1F, 1, 3'd6, 32'h8000_0000, 32'h1F, 32'h1, 0);
        run_op("lui",  3'b000, 0, 1, 1, 32'h1234, 32'h0, 32'hABCD_E000, 0, 3'd7, 32'h0, 32'h0, 32'hABCD_E000, 0);
        run_op("slt",  3'b010, 0, 0, 0, 32'h5, 32'h3, 32'h0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 1);
        run_op("sra",  3'b101, 1, 0, 0, 32'h8000_0000, 32'h1, 32'h0, 0, 3'd0, 32'h0, 32'h0, 32'h0, 1);
        run_op("wrap", 3'b000, 0, 0, 0, 32'hFFFF_FFFF, 32'h2, 32'h0, 1, 3'd0, 32'hFFFF_FFFF, 32'h2, 32'h1, 0);
        run_op("xor",  3'b100, 0, 0, 0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0, 1, 3'd4, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0F0F_F0F0, 0);
        run_op("and",  3'b111, 0, 0, 0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0, 1, 3'd2, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hF0F0_0000, 0);
        run_op("or",   3'b110, 0, 0, 0, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'h0, 1, 3'd3, 32'hF0F0_F0F0, 32'hFFFF_0000, 32'hFFFF_F0F0, 0);

        // Back-pressure with a second request held pending.
        @(negedge clk);
        set_req(3'b000, 0, 0, 0, 32'h2, 32'h3, 32'h0);
        @(negedge clk);
        set_req(3'b100, 0, 0, 0, 32'h1, 32'h3, 32'h0);
        @(negedge clk);
        chk("bp_rvalid", resp_valid, 1);
        chk("bp_data", resp_data, 32'h5);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_hold_rvalid", resp_valid, 1);
            chk("bp_hold_data", resp_data, 32'h5);
            chk("bp_hold_ready", req_ready, 0);
            chk("bp_hold_mode", alu_mode, 0);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_idle_ready", req_ready, 1);
        chk("bp_idle_rvalid", resp_valid, 0);
        chk("bp_idle_busy", busy, 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("bp2_busy", busy, 1);
        chk("bp2_mode", alu_mode, 3'd4);
        chk("bp2_rvalid", resp_valid, 0);
        @(negedge clk);
        chk("bp2_rvalid_on", resp_valid, 1);
        chk("bp2_data", resp_data, 32'h2);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp2_done", resp_valid, 0);

        // Asynchronous reset while holding a response.
        @(negedge clk);
        set_req(3'b000, 0, 0, 0, 32'h2, 32'h3, 32'h0);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        chk("ar_rvalid", resp_valid, 1);
        chk("ar_data", resp_data, 32'h5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_rvalid_drop", resp_valid, 0);
        chk("ar_ready", req_ready, 1);
        chk("ar_busy", busy, 0);
        @(negedge clk);
        rst_n      = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("ar_no_resp", resp_valid, 0);
        end
        resp_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
